// File: rtl/ac97_pkg.sv
// Frame geometry, tag bit positions and state type shared by the AC97 serial receive logic.
// Bit indices count from the first SDI bit after the sync rising edge (slot 0 bit 15 = index 0).
package ac97_pkg;

  localparam int FrameBits = 256;
  localparam int Slot0Bits = 16;
  localparam int SlotBits  = 20;

  localparam int Slot0Start = 0;
  localparam int Slot0End   = Slot0Start + Slot0Bits - 1;  // 15
  localparam int Slot1Start = Slot0End + 1;                // 16
  localparam int Slot1End   = Slot1Start + SlotBits - 1;   // 35
  localparam int Slot2Start = Slot1End + 1;                // 36
  localparam int Slot2End   = Slot2Start + SlotBits - 1;   // 55
  localparam int Slot3Start = Slot2End + 1;                // 56
  localparam int Slot3End   = Slot3Start + SlotBits - 1;   // 75
  localparam int Slot4Start = Slot3End + 1;                // 76
  localparam int Slot4End   = Slot4Start + SlotBits - 1;   // 95

  // Slot 0 tag layout: bit 15 = codec ready, bit (15-N) = slot N valid.
  localparam int TagReadyBit = 15;

  function automatic int tag_valid_bit(input int slot);
    return TagReadyBit - slot;
  endfunction

  localparam int TagSlot1Bit = tag_valid_bit(1);
  localparam int TagSlot2Bit = tag_valid_bit(2);
  localparam int TagSlot3Bit = tag_valid_bit(3);
  localparam int TagSlot4Bit = tag_valid_bit(4);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ac97_sdi_receiver.sv
// AC97 SDI frame deserialiser: tracks frame alignment from sync rising edges and extracts
// the slot 0 tag, the status register read-back (slots 1/2) and the stereo PCM pair (slots 3/4).
module ac97_sdi_receiver
  import ac97_pkg::*;
#(
  parameter int PcmWidth = 20,
  parameter int TagCheck = 1
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                AC97SDI,
  input  logic                AC97Sync,
  output logic                CodecReady,
  output logic                StatusValid,
  output logic [6:0]          StatusAddr,
  output logic [15:0]         StatusData,
  output logic                PcmValid,
  output logic [PcmWidth-1:0] PcmLeft,
  output logic [PcmWidth-1:0] PcmRight,
  output logic                SyncError
);

  state_t                state;
  logic [7:0]            cnt;
  logic                  sync_prev;
  logic [SlotBits-2:0]   shift;
  logic [4:1]            tag_valid;
  logic [6:0]            slot1_addr;
  logic [PcmWidth-1:0]   slot3_hold;

  logic                  frame_start;
  logic [SlotBits-1:0]   word;
  logic                  status_ok;
  logic                  pcm_ok;

  // word is the slot assembled including the bit sampled in this cycle
  assign frame_start = AC97Sync && !sync_prev;
  assign word        = {shift, AC97SDI};
  assign status_ok   = CodecReady && ((TagCheck == 0) || (tag_valid[1] && tag_valid[2]));
  assign pcm_ok      = CodecReady && ((TagCheck == 0) || (tag_valid[3] && tag_valid[4]));

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      sync_prev   <= 1'b0;
      shift       <= '0;
      tag_valid   <= '0;
      slot1_addr  <= '0;
      slot3_hold  <= '0;
      CodecReady  <= 1'b0;
      StatusValid <= 1'b0;
      StatusAddr  <= '0;
      StatusData  <= '0;
      PcmValid    <= 1'b0;
      PcmLeft     <= '0;
      PcmRight    <= '0;
      SyncError   <= 1'b0;
    end else begin
      sync_prev   <= AC97Sync;
      StatusValid <= 1'b0;
      PcmValid    <= 1'b0;
      SyncError   <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= RUN;
            cnt   <= 8'd1;
            shift <= {{(SlotBits-2){1'b0}}, AC97SDI};
          end
        end

        RUN: begin
          if (frame_start) begin
            // A sync edge anywhere but index 0 abandons the partial frame.
            if (cnt != 8'd0) SyncError <= 1'b1;
            cnt   <= 8'd1;
            shift <= {{(SlotBits-2){1'b0}}, AC97SDI};
          end else if (cnt == 8'd0) begin
            SyncError  <= 1'b1;
            state      <= IDLE;
            CodecReady <= 1'b0;
          end else begin
            cnt   <= cnt + 8'd1;
            shift <= word[SlotBits-2:0];

            if (cnt == 8'(Slot0End)) begin
              CodecReady   <= word[TagReadyBit];
              tag_valid[1] <= word[TagSlot1Bit];
              tag_valid[2] <= word[TagSlot2Bit];
              tag_valid[3] <= word[TagSlot3Bit];
              tag_valid[4] <= word[TagSlot4Bit];
            end

            if (cnt == 8'(Slot1End)) slot1_addr <= word[18:12];

            if (cnt == 8'(Slot2End) && status_ok) begin
              StatusValid <= 1'b1;
              StatusAddr  <= slot1_addr;
              StatusData  <= word[19:4];
            end

            // Left is parked until right arrives so both update together.
            if (cnt == 8'(Slot3End)) slot3_hold <= word[SlotBits-1 -: PcmWidth];

            if (cnt == 8'(Slot4End) && pcm_ok) begin
              PcmValid <= 1'b1;
              PcmLeft  <= slot3_hold;
              PcmRight <= word[SlotBits-1 -: PcmWidth];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac97_sdi_receiver.sv
// Scoreboarded bench for ac97_sdi_receiver: directed frames push expected pulses into queues,
// a negedge monitor pops and compares whenever the receiver presents a pulse.
module tb_ac97_sdi_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic        sync;

  logic        codec_ready, status_valid, pcm_valid, sync_error;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic [19:0] pcm_left, pcm_right;

  logic        c16_codec_ready, c16_status_valid, c16_pcm_valid, c16_sync_error;
  logic [6:0]  c16_status_addr;
  logic [15:0] c16_status_data;
  logic [15:0] c16_pcm_left, c16_pcm_right;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic [15:0] data;
  } st_exp_t;

  typedef struct {
    int          cyc;
    logic [19:0] l;
    logic [19:0] r;
  } pcm_exp_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pcm16_exp_t;

  st_exp_t    st_q[$];
  pcm_exp_t   pcm_q[$];
  pcm16_exp_t p16_q[$];
  int         err_q[$];

  ac97_sdi_receiver #(.PcmWidth(20), .TagCheck(1)) dut (
    .CLK(clk), .Rst(rst), .AC97SDI(sdi), .AC97Sync(sync),
    .CodecReady(codec_ready), .StatusValid(status_valid),
    .StatusAddr(status_addr), .StatusData(status_data),
    .PcmValid(pcm_valid), .PcmLeft(pcm_left), .PcmRight(pcm_right),
    .SyncError(sync_error)
  );

  ac97_sdi_receiver #(.PcmWidth(16), .TagCheck(1)) dut16 (
    .CLK(clk), .Rst(rst), .AC97SDI(sdi), .AC97Sync(sync),
    .CodecReady(c16_codec_ready), .StatusValid(c16_status_valid),
    .StatusAddr(c16_status_addr), .StatusData(c16_status_data),
    .PcmValid(c16_pcm_valid), .PcmLeft(c16_pcm_left), .PcmRight(c16_pcm_right),
    .SyncError(c16_sync_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("check %s ok: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse seen, none expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: every pulse the receiver presents is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    st_exp_t    se;
    pcm_exp_t   pe;
    pcm16_exp_t qe;
    int         ec;
    if (status_valid) begin
      if (st_q.size() == 0) unexpected("status_valid");
      else begin
        se = st_q.pop_front();
        chk("status_cycle", 32'(cyc), 32'(se.cyc));
        chk("status_addr", 32'(status_addr), 32'(se.addr));
        chk("status_data", 32'(status_data), 32'(se.data));
      end
    end
    if (pcm_valid) begin
      if (pcm_q.size() == 0) unexpected("pcm_valid");
      else begin
        pe = pcm_q.pop_front();
        chk("pcm_cycle", 32'(cyc), 32'(pe.cyc));
        chk("pcm_left", 32'(pcm_left), 32'(pe.l));
        chk("pcm_right", 32'(pcm_right), 32'(pe.r));
      end
    end
    if (c16_pcm_valid) begin
      if (p16_q.size() == 0) unexpected("pcm16_valid");
      else begin
        qe = p16_q.pop_front();
        chk("pcm16_left", 32'(c16_pcm_left), 32'(qe.l));
        chk("pcm16_right", 32'(c16_pcm_right), 32'(qe.r));
      end
    end
    if (sync_error) begin
      if (err_q.size() == 0) unexpected("sync_error");
      else begin
        ec = err_q.pop_front();
        chk("sync_error_cycle", 32'(cyc), 32'(ec));
      end
    end
    if (status_valid && pcm_valid) unexpected("status_and_pcm_same_cycle");
  end

  task automatic check_zero(input string tag);
    chk({tag, "_codec_ready"}, 32'(codec_ready), 32'd0);
    chk({tag, "_status_valid"}, 32'(status_valid), 32'd0);
    chk({tag, "_status_addr"}, 32'(status_addr), 32'd0);
    chk({tag, "_status_data"}, 32'(status_data), 32'd0);
    chk({tag, "_pcm_valid"}, 32'(pcm_valid), 32'd0);
    chk({tag, "_pcm_left"}, 32'(pcm_left), 32'd0);
    chk({tag, "_pcm_right"}, 32'(pcm_right), 32'd0);
    chk({tag, "_sync_error"}, 32'(sync_error), 32'd0);
    chk({tag, "_c16_all"}, 32'({c16_codec_ready, c16_status_valid, c16_pcm_valid, c16_sync_error}), 32'd0);
    chk({tag, "_c16_status"}, 32'({c16_status_addr, c16_status_data}), 32'd0);
    chk({tag, "_c16_pcm"}, {c16_pcm_left, c16_pcm_right}, 32'd0);
  endtask

  // Drives nbits of a frame; err_at_start expects a SyncError at index 0.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int nbits,
                            input int sync_len, input int rst_at, input bit err_at_start);
    logic [255:0] fr;
    fr = '0;
    fr[255 -: 16] = tag;
    fr[239 -: 20] = s1;
    fr[219 -: 20] = s2;
    fr[199 -: 20] = s3;
    fr[179 -: 20] = s4;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      sdi  = fr[255-i];
      sync = (i < sync_len);
      if (i == 0 && err_at_start) err_q.push_back(cyc + 1);
      if (i == 55 && (rst_at < 0 || i < rst_at) && tag[15] && tag[14] && tag[13])
        st_q.push_back('{cyc + 1, s1[18:12], s2[19:4]});
      if (i == 95 && (rst_at < 0 || i < rst_at) && tag[15] && tag[12] && tag[11]) begin
        pcm_q.push_back('{cyc + 1, s3, s4});
        p16_q.push_back('{s3[19:4], s4[19:4]});
      end
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_zero("midframe_reset");
      end
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
    end
    $display("frame tag=%h s1=%h s2=%h s3=%h s4=%h bits=%0d done (cycle %0d)",
             tag, s1, s2, s3, s4, nbits, cyc);
  endtask

  task automatic idle(input int n, input bit err_at_start);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sdi  = i[0] ^ i[2];
      sync = 1'b0;
      if (i == 0 && err_at_start) err_q.push_back(cyc + 1);
    end
    $display("idle %0d cycles done (cycle %0d)", n, cyc);
  endtask

  initial begin
    rst  = 1'b1;
    sdi  = 1'b0;
    sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(4, 1'b0);

    // Nominal frame, sync held longer than slot 0
    send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 256, 20, -1, 1'b0);
    // Ready but no slot-valid tags: nothing emitted, previous values held
    send_frame(16'h8000, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 256, 16, -1, 1'b0);
    chk("tag8000_codec_ready", 32'(codec_ready), 32'd1);
    chk("tag8000_hold_addr", 32'(status_addr), 32'h26);
    chk("tag8000_hold_data", 32'(status_data), 32'h000F);
    chk("tag8000_hold_left", 32'(pcm_left), 32'h12345);
    chk("tag8000_hold_right", 32'(pcm_right), 32'hABCDE);
    chk("tag8000_hold_left16", 32'(c16_pcm_left), 32'h1234);

    // Early sync at index 100, then again at index 40 (before any pulse)
    send_frame(16'hF800, 20'h7F000, 20'hBEEF0, 20'h80001, 20'h0FFFF, 100, 16, -1, 1'b0);
    send_frame(16'hF800, 20'h11000, 20'h99990, 20'h77777, 20'h88888, 40, 16, -1, 1'b1);
    // Status valid but slot 4 tag clear: status only
    send_frame(16'hF000, 20'h01000, 20'h12340, 20'h55555, 20'h66666, 256, 16, -1, 1'b1);
    chk("f000_hold_left", 32'(pcm_left), 32'h80001);
    chk("f000_hold_right", 32'(pcm_right), 32'h0FFFF);

    // Missing sync after a full frame: drop to idle, ignore data
    send_frame(16'hF800, 20'h3C000, 20'hABCD0, 20'hFFFFF, 20'h00000, 256, 16, -1, 1'b0);
    idle(280, 1'b1);
    chk("missing_sync_codec_ready", 32'(codec_ready), 32'd0);
    chk("missing_sync_hold_left", 32'(pcm_left), 32'hFFFFF);

    send_frame(16'hF800, 20'h05000, 20'h5A5A0, 20'h13579, 20'h2468A, 256, 16, -1, 1'b0);
    // Reset at index 50 for 3 cycles, then a clean frame
    send_frame(16'hF800, 20'h7F000, 20'hBEEF0, 20'h80001, 20'h0FFFF, 256, 16, 50, 1'b0);
    send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'hABCDE, 256, 16, -1, 1'b0);
    idle(10, 1'b1);

    chk("status_queue_drained", 32'(st_q.size()), 32'd0);
    chk("pcm_queue_drained", 32'(pcm_q.size()), 32'd0);
    chk("pcm16_queue_drained", 32'(p16_q.size()), 32'd0);
    chk("sync_error_queue_drained", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac97_sdi_receiver.md
AC97_SDI_RECEIVER -- requirements
Module: ac97_sdi_receiver

Interface
REQ-001 Parameter PcmWidth, default 20, output PCM width (16..20); the receiver keeps the MSBs of each 20-bit slot.
REQ-002 Parameter TagCheck, default 1, with 1 requiring the slot-valid tag bits before output pulses, and 0 ignoring the tags.
REQ-003 CLK  input  1  AC97 bit clock (12.288 MHz), with all logic on the rising edge.
REQ-004 Rst  input  1  Asynchronous, active-high reset.
REQ-005 AC97SDI  input  1  Serial data from the LM4550, MSB first.
REQ-006 AC97Sync  input  1  Frame sync, as driven by the controller toward the codec.
REQ-007 CodecReady  output  1  Slot 0 bit 15 of the last complete tag.
REQ-008 StatusValid  output  1  One-cycle pulse when StatusAddr/StatusData update.
REQ-009 StatusAddr  output  7  Slot 1 bits 18:12, the register index.
REQ-010 StatusData  output  16  Slot 2 bits 19:4.
REQ-011 PcmValid  output  1  One-cycle pulse when PcmLeft/PcmRight update.
REQ-012 PcmLeft  output  PcmWidth  Slot 3 bits 19:(20-PcmWidth).
REQ-013 PcmRight  output  PcmWidth  Slot 4 bits 19:(20-PcmWidth).
REQ-014 SyncError  output  1  One-cycle pulse on frame misalignment.

Function
REQ-015 Frame format: 256 bits, with slot 0 = 16 bits and slots 1..12 = 20 bits each; slot 1 occupies bit indices 16..35, slot 2 36..55, slot 3 56..75, and slot 4 76..95.
REQ-016 Frame start occurs in the cycle where AC97Sync is sampled 1 and was 0 in the prior cycle; the SDI bit sampled in that cycle is bit index 0 (slot 0 bit 15).
REQ-017 State machine IDLE/RUN: IDLE → RUN at frame start with bit counter = 0; in RUN the 8-bit counter increments each cycle and wraps from 255 to 0.
REQ-018 In IDLE, the block ignores SDI and asserts no Valid pulses.
REQ-019 Slot 0 is latched at index 15; CodecReady and the tag register update in the following cycle.
REQ-020 StatusValid pulses in the cycle after index 55 iff CodecReady and either TagCheck=0 or (tag slot1 and tag slot2 are valid); StatusAddr/StatusData update in that same cycle.
REQ-021 PcmValid pulses in the cycle after index 95 iff CodecReady and either TagCheck=0 or (tag slot3 and tag slot4 are valid); PcmLeft/PcmRight update together in that cycle, with no torn samples.
REQ-022 Outputs hold their values between pulses; slots 5..12 are discarded.
REQ-023 Early sync: a frame start seen in RUN with counter ≠ 0 pulses SyncError, discards the partial frame, suppresses the pending pulses, and restarts at index 0.
REQ-024 Missing sync: the counter wrapping to 0 without a frame start in that cycle pulses SyncError, goes to IDLE, and clears CodecReady.
REQ-025 AC97Sync high longer than 16 cycles is not an error; only rising edges matter.
REQ-026 StatusValid and PcmValid are never asserted in the same cycle, by construction.

Reset
REQ-027 Asynchronous Rst forces IDLE, counter 0, sync history 0, and all outputs 0, including pulses.
REQ-028 On Rst mid-frame, the partial frame produces no pulse after release; reception resumes at the next frame start.

Structure
REQ-029 Shared package ac97_pkg holds FrameBits=256, Slot0Bits=16, SlotBits=20, the slot start/end indices, tag bit positions (ready=15, slotN valid=15-N), and the state type.
REQ-030 The block is a single module with no sub-module; one shift register is shared across slots.

Verification
REQ-031 Valid frame, tag=16'hF800 (ready and slots 1..4 valid), slot1=20'h26000, slot2=20'h000F0, slot3=20'h12345, slot4=20'hABCDE → StatusAddr=7'h26 and StatusData=16'h000F with StatusValid 1 cycle after index 55; PcmLeft=20'h12345 and PcmRight=20'hABCDE with PcmValid 1 cycle after index 95.
REQ-032 Tag=16'h8000 with TagCheck=1 → no StatusValid or PcmValid pulses, CodecReady=1, and prior output values are held.
REQ-033 PcmWidth=16 with slot3=20'h12345 → PcmLeft=16'h1234.
REQ-034 Sync rising at index 100 → one SyncError pulse, and the next frame decodes normally from index 0.
REQ-035 Sync absent after index 255 → SyncError pulse, IDLE, CodecReady=0, and no pulses until the next sync edge.
REQ-036 Rst asserted at index 50 and released 3 cycles later → all outputs 0 and no StatusValid; the next full frame decodes correctly.
